fifo_read_ctrl: RTL and testbench

Read-side pointer and flag controller for the team's FIFO; companion to the write-side controller that generates wrPtr and the full flag. It owns the read pointer (index plus wrap/phase MSB), derives empty, occupancy and almost-empty status against the incoming write pointer, and issues the memory read address and a read-data-valid strobe. Single clock domain: wrPtr arrives synchronous to rd_clk.

---
 rtl/fifo_read_ctrl.sv | 82 ++++++++
 tb/tb_fifo_read_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side pointer/flag controller: read pointer, empty, count, almost-empty.
// Optional FIFO_RD_UNDERFLOW_CLR_EN adds rd_uf_clr to clear the sticky underflow.
module fifo_read_ctrl #(
  parameter int N        = 8,
  parameter int DEPTH    = 100,
  parameter int AE_LEVEL = 4
) (
  input  logic         rd_clk,
  input  logic         rd_rst,
  input  logic         rd_en,
`ifdef FIFO_RD_UNDERFLOW_CLR_EN
  input  logic         rd_uf_clr,
`endif
  input  logic [N-1:0] wrPtr,
  output logic [N-1:0] rdPtr,
  output logic [N-2:0] o_rd_addr,
  output logic         o_rd_valid,
  output logic         o_fifo_empty,
  output logic         o_almost_empty,
  output logic [N-1:0] o_count,
  output logic         o_underflow
);

  localparam int IW = N - 1;
  localparam logic [N:0]    DEPTH_X = (N+1)'(DEPTH);
  localparam logic [N:0]    AE_X    = (N+1)'(AE_LEVEL);
  localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          rd_ph;
  logic          wr_ph;
  logic [N:0]    rd_x;
  logic [N:0]    wr_x;
  logic [N:0]    cnt_x;
  logic          accept;

  assign rd_idx = rdPtr[IW-1:0];
  assign wr_idx = wrPtr[IW-1:0];
  assign rd_ph  = rdPtr[N-1];
  assign wr_ph  = wrPtr[N-1];
  assign rd_x   = {2'b00, rd_idx};
  assign wr_x   = {2'b00, wr_idx};

  // DEPTH need not be a power of two, so the phase-differ case adds DEPTH.
  always_comb begin
    cnt_x = '0;
    if (rd_ph == wr_ph)
      cnt_x = wr_x - rd_x;
    else
      cnt_x = DEPTH_X - rd_x + wr_x;
  end

  assign o_count        = cnt_x[N-1:0];
  assign o_fifo_empty   = (rdPtr == wrPtr);
  assign o_almost_empty = ({1'b0, o_count} <= AE_X);
  assign o_rd_addr      = rd_idx;
  assign accept         = rd_en & ~o_fifo_empty;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rdPtr       <= '0;
      o_rd_valid  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_rd_valid <= accept;
      if (accept) begin
        if (rd_idx == LAST)
          rdPtr <= {~rd_ph, {IW{1'b0}}};
        else
          rdPtr <= {rd_ph, rd_idx + IW'(1)};
      end
      if (rd_en & o_fifo_empty)
        o_underflow <= 1'b1;
`ifdef FIFO_RD_UNDERFLOW_CLR_EN
      else if (rd_uf_clr)
        o_underflow <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: absolute-position model plus
// directed scenarios and randomized read/write traffic.
module tb_fifo_read_ctrl;
  localparam int N = 8;
  localparam int D = 100;
  localparam int AE = 4;
  localparam int SPAN = 2 * D;

  logic         rd_clk = 1'b0;
  logic         rd_rst = 1'b0;
  logic         rd_en = 1'b0;
  logic         rd_uf_clr = 1'b0;
  logic [N-1:0] wrPtr = '0;
  logic [N-1:0] rdPtr;
  logic [N-2:0] o_rd_addr;
  logic         o_rd_valid;
  logic         o_fifo_empty;
  logic         o_almost_empty;
  logic [N-1:0] o_count;
  logic         o_underflow;

  int total = 0;
  int bad = 0;
  int wabs = 0;

  // model state: read position on a 0..2*DEPTH-1 circle
  int m_rabs = 0;
  bit m_valid = 0;
  bit m_uf = 0;

  fifo_read_ctrl #(.N(N), .DEPTH(D), .AE_LEVEL(AE)) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .rd_en(rd_en),
`ifdef FIFO_RD_UNDERFLOW_CLR_EN
    .rd_uf_clr(rd_uf_clr),
`endif
    .wrPtr(wrPtr),
    .rdPtr(rdPtr),
    .o_rd_addr(o_rd_addr),
    .o_rd_valid(o_rd_valid),
    .o_fifo_empty(o_fifo_empty),
    .o_almost_empty(o_almost_empty),
    .o_count(o_count),
    .o_underflow(o_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic logic [N-1:0] enc(input int a);
    logic [N-1:0] p;
    p = N'(a % D);
    p[N-1] = (a >= D);
    return p;
  endfunction

  function automatic int dec(input logic [N-1:0] p);
    return (p[N-1] ? D : 0) + int'(p[N-2:0]);
  endfunction

  function automatic int occ(input int w, input int r);
    return (w - r + SPAN) % SPAN;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic setw(input int a);
    wabs = a % SPAN;
    wrPtr = enc(wabs);
  endtask

  // reference model, evaluated on pre-edge inputs
  always @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      m_rabs  <= 0;
      m_valid <= 1'b0;
      m_uf    <= 1'b0;
    end else begin
      m_valid <= rd_en && occ(dec(wrPtr), m_rabs) != 0;
      if (rd_en && occ(dec(wrPtr), m_rabs) != 0)
        m_rabs <= (m_rabs + 1) % SPAN;
      if (rd_en && occ(dec(wrPtr), m_rabs) == 0)
        m_uf <= 1'b1;
`ifdef FIFO_RD_UNDERFLOW_CLR_EN
      else if (rd_uf_clr)
        m_uf <= 1'b0;
`endif
    end
  end

  // per-cycle comparison against the model
  always @(negedge rd_clk) begin
    int c;
    c = occ(dec(wrPtr), m_rabs);
    chk("m_rdPtr", int'(rdPtr), int'(enc(m_rabs)));
    chk("m_addr", int'(o_rd_addr), m_rabs % D);
    chk("m_valid", int'(o_rd_valid), int'(m_valid));
    chk("m_empty", int'(o_fifo_empty), int'(c == 0));
    chk("m_count", int'(o_count), c);
    chk("m_ae", int'(o_almost_empty), int'(c <= AE));
    chk("m_uf", int'(o_underflow), int'(m_uf));
  end

  task automatic reset_mid();
    #2 rd_rst = 1'b1;
    #1;
    tick();
    tick();
    rd_rst = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rd_en = 1'b0;
    tick();
  endtask

  initial begin
    int wp;
    // 1: reset asserted mid-cycle
    #2 rd_rst = 1'b1;
    #1;
    chk("rst_ptr", int'(rdPtr), 0);
    chk("rst_empty", int'(o_fifo_empty), 1);
    chk("rst_count", int'(o_count), 0);
    chk("rst_ae", int'(o_almost_empty), 1);
    chk("rst_valid", int'(o_rd_valid), 0);
    chk("rst_uf", int'(o_underflow), 0);
    tick();
    tick();
    rd_rst = 1'b0;

    // 2: five reads from five entries
    setw(5);
    rd_en = 1'b1;
    #1;
    chk("b_ae0", int'(o_almost_empty), 0);
    for (int i = 0; i < 5; i++) begin
      chk("b_addr", int'(o_rd_addr), i);
      chk("b_count", int'(o_count), 5 - i);
      tick();
      chk("b_valid", int'(o_rd_valid), 1);
      chk("b_ae", int'(o_almost_empty), 1);
    end
    chk("b_empty", int'(o_fifo_empty), 1);
    chk("b_cnt0", int'(o_count), 0);
    tick();
    chk("b_vfall", int'(o_rd_valid), 0);
    chk("b_noud", int'(rdPtr), 5);
    chk("b_uf", int'(o_underflow), 1);
    rd_en = 1'b0;
    reset_mid();

    // 3: wrap from index 98 to phase 1
    setw(98);
    drain(98);
    chk("w_pos", int'(rdPtr), 8'h62);
    wrPtr = 8'h82;
    wabs = dec(wrPtr);
    rd_en = 1'b1;
    #1;
    chk("w_cnt4", int'(o_count), 4);
    chk("w_p0", int'(rdPtr), 8'h62);
    tick();
    chk("w_p1", int'(rdPtr), 8'h63);
    chk("w_c3", int'(o_count), 3);
    tick();
    chk("w_p2", int'(rdPtr), 8'h80);
    chk("w_c2", int'(o_count), 2);
    tick();
    chk("w_p3", int'(rdPtr), 8'h81);
    chk("w_c1", int'(o_count), 1);
    tick();
    chk("w_p4", int'(rdPtr), 8'h82);
    chk("w_c0", int'(o_count), 0);
    rd_en = 1'b0;
    tick();

    // 4: underflow on empty FIFO, sticky while idle
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("u_ptr", int'(rdPtr), 8'h82);
    chk("u_valid", int'(o_rd_valid), 0);
    chk("u_set", int'(o_underflow), 1);
    for (int i = 0; i < 10; i++) tick();
    chk("u_hold", int'(o_underflow), 1);
`ifdef FIFO_RD_UNDERFLOW_CLR_EN
    rd_uf_clr = 1'b1;
    tick();
    rd_uf_clr = 1'b0;
    chk("u_clr", int'(o_underflow), 0);
    rd_en = 1'b1;
    rd_uf_clr = 1'b1;
    tick();
    rd_en = 1'b0;
    rd_uf_clr = 1'b0;
    chk("u_setwins", int'(o_underflow), 1);
`endif
    reset_mid();
    chk("u_rstclr", int'(o_underflow), 0);

    // 5: read and write together at count 3 across the wrap
    setw(90);
    drain(90);
    setw(93);
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1 chk("s_cnt", int'(o_count), 3);
      tick();
      setw(wabs + 1);
    end
    rd_en = 1'b0;
    chk("s_ptr", int'(rdPtr), 8'h8A);
    tick();
    reset_mid();

    // 6: reset during back-to-back reads
    setw(64);
    drain(64);
    setw(80);
    rd_en = 1'b1;
    #1 chk("r_at40", int'(rdPtr), 8'h40);
    tick();
    tick();
    #1 rd_rst = 1'b1;
    #1;
    chk("r_ptr", int'(rdPtr), 0);
    chk("r_valid", int'(o_rd_valid), 0);
    tick();
    chk("r_noval", int'(o_rd_valid), 0);
    chk("r_ptr2", int'(rdPtr), 0);
    rd_en = 1'b0;
    rd_rst = 1'b0;
    setw(0);
    tick();

    // randomized traffic in phases of differing write pressure
    for (int ph = 0; ph < 4; ph++) begin
      wp = (ph == 0) ? 70 : (ph == 1) ? 20 : (ph == 2) ? 50 : 90;
      for (int i = 0; i < 300; i++) begin
        rd_en = ($urandom_range(0, 99) < 60);
`ifdef FIFO_RD_UNDERFLOW_CLR_EN
        rd_uf_clr = ($urandom_range(0, 99) < 5);
`endif
        tick();
        if (occ(wabs, m_rabs) < D && $urandom_range(0, 99) < wp)
          setw(wabs + 1);
      end
    end
    rd_en = 1'b0;
    rd_uf_clr = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
